// File: rtl/proc_pkg.sv
// Shared definitions for the multicycle processor: fetch FSM encoding,
// default datapath widths and instruction field positions.
package proc_pkg;

  typedef enum logic {
    S_FETCH = 1'b0,
    S_HOLD  = 1'b1
  } fetch_state_e;

  localparam int ADDR_W_DEF  = 16;
  localparam int INSTR_W_DEF = 16;

  localparam int OPC_HI  = 15;
  localparam int OPC_LO  = 12;
  localparam int REGX_HI = 11;
  localparam int REGX_LO = 9;
  localparam int REGY_HI = 8;
  localparam int REGY_LO = 6;

  localparam int FETCH_CNT_W = 16;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch stage: requests the word at the current PC, latches it into
// the IR, pulses the PC increment and holds the IR until the control unit takes it.
module instr_fetch
  import proc_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic                   p_Clock,
  input  logic                   p_Reset,
  input  logic [ADDR_W-1:0]      p_PC,
  output logic                   p_IncPC,
  output logic                   p_MemReq,
  output logic [ADDR_W-1:0]      p_MemAddr,
  input  logic                   p_MemReady,
  input  logic [INSTR_W-1:0]     p_MemData,
  output logic [INSTR_W-1:0]     p_Instr,
  output logic [3:0]             p_Opcode,
  output logic [2:0]             p_RegX,
  output logic [2:0]             p_RegY,
  output logic                   p_InstrValid,
  input  logic                   p_InstrAccept,
  input  logic                   p_Flush,
  output logic [FETCH_CNT_W-1:0] p_FetchCount
);

  fetch_state_e           state_q, state_d;
  logic [INSTR_W-1:0]     ir_q, ir_d;
  logic [FETCH_CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
  logic                   fetch_done;

  // A fetch completes only when memory answers in S_FETCH and no jump is
  // redirecting the PC; a flushed answer is dropped on the floor.
  assign fetch_done = (state_q == S_FETCH) && p_MemReady && !p_Flush && !p_Reset;

  always_ff @(posedge p_Clock) begin
    if (p_Reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (p_Flush) begin
      state_d = S_FETCH;
    end else begin
      unique case (state_q)
        S_FETCH: if (p_MemReady)    state_d = S_HOLD;
        S_HOLD:  if (p_InstrAccept) state_d = S_FETCH;
        default:                    state_d = S_FETCH;
      endcase
    end
  end

  always_comb begin
    p_MemReq     = (state_q == S_FETCH) && !p_Reset;
    p_MemAddr    = p_MemReq ? p_PC : '0;
    p_IncPC      = fetch_done;
    p_InstrValid = (state_q == S_HOLD);
  end

  always_comb begin
    ir_d        = ir_q;
    fetch_cnt_d = fetch_cnt_q;
    if (fetch_done) begin
      ir_d        = p_MemData;
      fetch_cnt_d = fetch_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge p_Clock) begin
    if (p_Reset) begin
      ir_q        <= '0;
      fetch_cnt_q <= '0;
    end else begin
      ir_q        <= ir_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  assign p_Instr      = ir_q;
  assign p_Opcode     = ir_q[OPC_HI:OPC_LO];
  assign p_RegX       = ir_q[REGX_HI:REGX_LO];
  assign p_RegY       = ir_q[REGY_HI:REGY_LO];
  assign p_FetchCount = fetch_cnt_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: reset, wait states, held IR, flushes,
// back-to-back fetches and fetch counter wrap.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pc;
  logic        inc_pc;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ready;
  logic [15:0] mem_data;
  logic [15:0] instr;
  logic [3:0]  opcode;
  logic [2:0]  reg_x;
  logic [2:0]  reg_y;
  logic        instr_valid;
  logic        instr_accept;
  logic        flush;
  logic [15:0] fetch_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  instr_fetch #(.ADDR_W(16), .INSTR_W(16)) dut (
    .p_Clock      (clk),
    .p_Reset      (rst),
    .p_PC         (pc),
    .p_IncPC      (inc_pc),
    .p_MemReq     (mem_req),
    .p_MemAddr    (mem_addr),
    .p_MemReady   (mem_ready),
    .p_MemData    (mem_data),
    .p_Instr      (instr),
    .p_Opcode     (opcode),
    .p_RegX       (reg_x),
    .p_RegY       (reg_y),
    .p_InstrValid (instr_valid),
    .p_InstrAccept(instr_accept),
    .p_Flush      (flush),
    .p_FetchCount (fetch_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; pc = 16'h0000; mem_ready = 1'b1; mem_data = 16'hA2C0;
    instr_accept = 1'b0; flush = 1'b0;
    tick(); tick();
    total++; if (mem_req !== 1'b0) begin $display("FAIL rst_memreq got=%b exp=0", mem_req); bad++; end
    total++; if (inc_pc !== 1'b0) begin $display("FAIL rst_incpc got=%b exp=0", inc_pc); bad++; end
    total++; if (instr !== 16'h0000) begin $display("FAIL rst_ir got=%h exp=0000", instr); bad++; end
    total++; if (instr_valid !== 1'b0) begin $display("FAIL rst_valid got=%b exp=0", instr_valid); bad++; end
    total++; if (fetch_count !== 16'h0000) begin $display("FAIL rst_count got=%h exp=0000", fetch_count); bad++; end
    rst = 1'b0;
    #1;
    total++; if (mem_req !== 1'b1) begin $display("FAIL first_memreq got=%b exp=1", mem_req); bad++; end
    total++; if (mem_addr !== 16'h0000) begin $display("FAIL first_addr got=%h exp=0000", mem_addr); bad++; end
    total++; if (inc_pc !== 1'b1) begin $display("FAIL first_incpc got=%b exp=1", inc_pc); bad++; end
    tick();
    mem_ready = 1'b0;
    #1;
    total++; if (instr !== 16'hA2C0) begin $display("FAIL first_ir got=%h exp=a2c0", instr); bad++; end
    total++; if (opcode !== 4'hA) begin $display("FAIL first_opcode got=%h exp=a", opcode); bad++; end
    total++; if (reg_x !== 3'd1) begin $display("FAIL first_regx got=%0d exp=1", reg_x); bad++; end
    total++; if (reg_y !== 3'd3) begin $display("FAIL first_regy got=%0d exp=3", reg_y); bad++; end
    total++; if (instr_valid !== 1'b1) begin $display("FAIL first_valid got=%b exp=1", instr_valid); bad++; end
    total++; if (fetch_count !== 16'h0001) begin $display("FAIL first_count got=%h exp=0001", fetch_count); bad++; end
    total++; if (mem_req !== 1'b0) begin $display("FAIL hold_memreq got=%b exp=0", mem_req); bad++; end
    total++; if (mem_addr !== 16'h0000) begin $display("FAIL hold_addr got=%h exp=0000", mem_addr); bad++; end
    instr_accept = 1'b1;
    tick();
    instr_accept = 1'b0;
    #1;
    total++; if (instr_valid !== 1'b0) begin $display("FAIL accept_valid got=%b exp=0", instr_valid); bad++; end
    total++; if (mem_req !== 1'b1) begin $display("FAIL accept_memreq got=%b exp=1", mem_req); bad++; end
  endtask

  task automatic test_wait_states();
    int pulses = 0;
    pc = 16'h0010; mem_ready = 1'b0; mem_data = 16'h1234;
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3);
      #1;
      total++; if (mem_req !== 1'b1) begin $display("FAIL wait_memreq cyc=%0d got=%b exp=1", i, mem_req); bad++; end
      total++; if (mem_addr !== 16'h0010) begin $display("FAIL wait_addr cyc=%0d got=%h exp=0010", i, mem_addr); bad++; end
      if (inc_pc === 1'b1) pulses++;
      tick();
    end
    // memory keeps ready high in S_HOLD; it must be ignored
    for (int i = 0; i < 2; i++) begin
      if (inc_pc === 1'b1) pulses++;
      tick();
    end
    mem_ready = 1'b0;
    total++; if (pulses !== 1) begin $display("FAIL wait_pulses got=%0d exp=1", pulses); bad++; end
    total++; if (instr !== 16'h1234) begin $display("FAIL wait_ir got=%h exp=1234", instr); bad++; end
    total++; if (fetch_count !== 16'h0002) begin $display("FAIL wait_count got=%h exp=0002", fetch_count); bad++; end
  endtask

  task automatic test_hold();
    instr_accept = 1'b0; mem_data = 16'hBEEF; mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++; if (instr !== 16'h1234) begin $display("FAIL hold_ir cyc=%0d got=%h exp=1234", i, instr); bad++; end
      total++; if (mem_req !== 1'b0 || inc_pc !== 1'b0) begin $display("FAIL hold_req_inc cyc=%0d got=%b%b exp=00", i, mem_req, inc_pc); bad++; end
      total++; if (instr_valid !== 1'b1) begin $display("FAIL hold_valid cyc=%0d got=%b exp=1", i, instr_valid); bad++; end
      tick();
    end
    mem_ready = 1'b0; instr_accept = 1'b1;
    tick();
    instr_accept = 1'b0;
    #1;
    total++; if (mem_req !== 1'b1) begin $display("FAIL hold_newreq got=%b exp=1", mem_req); bad++; end
    total++; if (fetch_count !== 16'h0002) begin $display("FAIL hold_count got=%h exp=0002", fetch_count); bad++; end
  endtask

  task automatic test_flush_fetch();
    pc = 16'h0020; mem_ready = 1'b1; mem_data = 16'hFFFF; flush = 1'b1;
    #1;
    total++; if (inc_pc !== 1'b0) begin $display("FAIL flushf_incpc got=%b exp=0", inc_pc); bad++; end
    tick();
    flush = 1'b0; pc = 16'h0040; mem_ready = 1'b0;
    #1;
    total++; if (instr !== 16'h1234) begin $display("FAIL flushf_ir got=%h exp=1234", instr); bad++; end
    total++; if (fetch_count !== 16'h0002) begin $display("FAIL flushf_count got=%h exp=0002", fetch_count); bad++; end
    total++; if (instr_valid !== 1'b0) begin $display("FAIL flushf_valid got=%b exp=0", instr_valid); bad++; end
    total++; if (mem_req !== 1'b1 || mem_addr !== 16'h0040) begin $display("FAIL flushf_newreq got=%b/%h exp=1/0040", mem_req, mem_addr); bad++; end
    mem_ready = 1'b1; mem_data = 16'h5E40;
    tick();
    mem_ready = 1'b0;
    #1;
    total++; if (instr !== 16'h5E40 || fetch_count !== 16'h0003) begin $display("FAIL flushf_refetch got=%h/%h exp=5e40/0003", instr, fetch_count); bad++; end
  endtask

  task automatic test_flush_hold();
    total++; if (instr_valid !== 1'b1) begin $display("FAIL flushh_pre_valid got=%b exp=1", instr_valid); bad++; end
    instr_accept = 1'b1; flush = 1'b1; pc = 16'h0080;
    tick();
    instr_accept = 1'b0; flush = 1'b0;
    #1;
    total++; if (instr_valid !== 1'b0) begin $display("FAIL flushh_valid got=%b exp=0", instr_valid); bad++; end
    total++; if (mem_req !== 1'b1 || mem_addr !== 16'h0080) begin $display("FAIL flushh_fetch got=%b/%h exp=1/0080", mem_req, mem_addr); bad++; end
    total++; if (instr !== 16'h5E40 || fetch_count !== 16'h0003) begin $display("FAIL flushh_keep got=%h/%h exp=5e40/0003", instr, fetch_count); bad++; end
  endtask

  task automatic test_reset_mid_wait();
    mem_ready = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    total++; if (mem_req !== 1'b0 || inc_pc !== 1'b0) begin $display("FAIL midrst_req got=%b%b exp=00", mem_req, inc_pc); bad++; end
    tick();
    rst = 1'b0;
    #1;
    total++; if (instr !== 16'h0000 || fetch_count !== 16'h0000) begin $display("FAIL midrst_state got=%h/%h exp=0000/0000", instr, fetch_count); bad++; end
    total++; if (mem_req !== 1'b1) begin $display("FAIL midrst_resume got=%b exp=1", mem_req); bad++; end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    mem_ready = 1'b1; instr_accept = 1'b1; mem_data = 16'h3000;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (inc_pc === 1'b1) pulses++;
      tick();
    end
    total++; if (pulses !== 2 || fetch_count !== 16'h0002) begin $display("FAIL b2b got=%0d/%h exp=2/0002", pulses, fetch_count); bad++; end
  endtask

  task automatic test_count_wrap();
    // still in S_FETCH with ready and accept high: two cycles per fetch
    for (int i = 0; i < 65533; i++) begin
      tick(); tick();
    end
    total++; if (fetch_count !== 16'hFFFF) begin $display("FAIL wrap_pre got=%h exp=ffff", fetch_count); bad++; end
    tick(); tick();
    total++; if (fetch_count !== 16'h0000) begin $display("FAIL wrap_post got=%h exp=0000", fetch_count); bad++; end
    mem_ready = 1'b0; instr_accept = 1'b0;
  endtask

  initial begin
    test_reset();
    test_wait_states();
    test_hold();
    test_flush_fetch();
    test_flush_hold();
    test_reset_mid_wait();
    test_back_to_back();
    test_count_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage of the multicycle processor, directly downstream of the program counter. It reads the current PC value, issues a request to instruction memory, captures the returned word into the instruction register (IR), and pulses the PC increment. It then holds the instruction for the control unit until the control unit accepts it. Jumps flush the stage while the PC loads its new target.

## Interface

**Parameters**
- `ADDR_W`, 16: PC / memory address width
- `INSTR_W`, 16: instruction width

**Ports**
- `p_Clock`  in  1  system clock; all state updates on posedge
- `p_Reset`  in  1  synchronous, active-high reset
- `p_PC`  in  ADDR_W  current PC value, from the PC block
- `p_IncPC`  out  1  one-cycle pulse to the PC; PC increments on that edge
- `p_MemReq`  out  1  instruction memory read request
- `p_MemAddr`  out  ADDR_W  read address; equals `p_PC` while `p_MemReq`=1, else 0
- `p_MemReady`  in  1  memory has valid `p_MemData` this cycle
- `p_MemData`  in  INSTR_W  instruction word returned by memory
- `p_Instr`  out  INSTR_W  IR contents
- `p_Opcode`  out  4  `IR[15:12]`
- `p_RegX`  out  3  `IR[11:9]`
- `p_RegY`  out  3  `IR[8:6]`
- `p_InstrValid`  out  1  IR holds an instruction not yet accepted
- `p_InstrAccept`  in  1  control unit consumes the IR this cycle
- `p_Flush`  in  1  asserted in the same cycle the PC's `p_Load` is asserted (jump/branch taken)
- `p_FetchCount`  out  16  number of completed fetches, wraps modulo 2^16

## Operation

**States:** `S_FETCH`, `S_HOLD`.

**Reset** (`p_Reset`=1 at posedge): state `S_FETCH`, IR=0, `p_InstrValid`=0, `p_FetchCount`=0. While `p_Reset` is high, `p_MemReq`=0 and `p_IncPC`=0.

**`S_FETCH`**
- `p_MemReq`=1 and `p_MemAddr`=`p_PC`, held until `p_MemReady`.
- On `p_MemReady`=1 and `p_Flush`=0:
  - IR<=`p_MemData`
  - `p_IncPC`=1 for this cycle only
  - `p_FetchCount`<=`p_FetchCount`+1
  - next state `S_HOLD`
- `p_MemReady`=0: stay in `S_FETCH`.

**`S_HOLD`**
- `p_InstrValid`=1 and `p_MemReq`=0.
- On `p_InstrAccept`=1: next state `S_FETCH`, and `p_InstrValid` falls on that edge.
- `p_InstrAccept`=0: hold IR unchanged indefinitely.

**Flush** (`p_Flush`=1, any state, highest priority after reset)
- Next state `S_FETCH`, `p_InstrValid`<=0, IR unchanged.
- `p_IncPC`=0 in that cycle, even if `p_MemReady`=1; that memory data is discarded and `p_FetchCount` is not incremented.

**Boundary cases**
- `p_MemReady` outside `S_FETCH`: ignored.
- `p_InstrAccept` while `p_InstrValid`=0: ignored.
- `p_InstrAccept` and `p_Flush` in the same cycle: the flush rule applies.
- PC wrap 0xFFFF→0x0000 is handled by the PC block; this block has no special case for it.
- `p_FetchCount` wraps 0xFFFF→0x0000.
- Reset mid-fetch or mid-hold: the reset values apply on that edge, and any outstanding request is abandoned. Memory must tolerate `p_MemReq` dropping before ready.

## Timing

- `p_MemReq`, `p_MemAddr`, `p_IncPC` and `p_InstrValid` are combinational from state and registered values. `p_IncPC` additionally depends combinationally on `p_MemReady` and `p_Flush`.
- **Minimum fetch latency:** 1 cycle, when memory returns `p_MemReady` in the first request cycle. IR and `p_InstrValid` are visible the cycle after the ready cycle.
- **Back-to-back throughput:** one instruction per 2 cycles with zero-wait memory and immediate accept.
- **After a flush:** the request for the new PC target is issued in the cycle immediately following the flush edge. `p_PC` already reflects the loaded value in that cycle.
- The PC increment and the IR load occur on the same edge.

## Structure

- **Shared package `proc_pkg`:**
  - fetch state enum (`S_FETCH`=1'b0, `S_HOLD`=1'b1)
  - `ADDR_W`/`INSTR_W` defaults
  - opcode field bounds (15:12), RegX (11:9), RegY (8:6)
- No sub-module: a single FSM with IR and counter registers, implemented inline.

## Test plan

- **Reset release, zero-wait memory, `p_PC`=0x0000, memory word 0xA2C0:**
  - `p_MemAddr`=0x0000 and `p_IncPC`=1 in the first cycle.
  - Next cycle: `p_Instr`=0xA2C0, `p_Opcode`=0xA, `p_RegX`=1, `p_RegY`=3, `p_InstrValid`=1, `p_FetchCount`=1.
- **Memory with 3 wait cycles:** `p_MemReq` held 4 cycles with a stable address, then exactly one `p_IncPC` pulse and no duplicate increment.
- **Accept withheld for 5 cycles:** IR stable, `p_MemReq`=0, and no `p_IncPC` for the whole period. Accept → new request in the following cycle.
- **`p_Flush` together with `p_MemReady` in `S_FETCH`:** `p_IncPC`=0, IR unchanged, count unchanged. Next request uses the new `p_PC` (e.g. 0x0040).
- **`p_Flush` in `S_HOLD` with `p_InstrAccept`=1:** `p_InstrValid`=0 next cycle, and `S_FETCH` is entered.
- **Reset pulsed mid-wait; separately, 65536 fetches:**
  - Mid-wait reset: `p_MemReq`=0 during reset, IR=0, count=0 afterwards.
  - 65536 fetches: `p_FetchCount` returns to 0x0000.
